// File: rtl/serial_magnitude_comparator_if.sv
// rtl/serial_magnitude_comparator_if.sv - start/done handshake and result bundle for the serial comparator
interface serial_magnitude_comparator_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             busy;
   logic             done;
   logic             greater;
   logic             less;
   logic             equal;

   modport master (
      output start, a_in, b_in,
      input  busy, done, greater, less, equal
   );

   modport slave (
      input  start, a_in, b_in,
      output busy, done, greater, less, equal
   );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - bit-serial MSB-first magnitude comparator with start/done handshake
// Optional SERIAL_CMP_EARLY_EXIT_EN finishes at the first differing bit.
module serial_magnitude_comparator #(
   parameter int WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   serial_magnitude_comparator_if.slave cmp
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             rg_q, rg_d, rl_q, rl_d, re_q, re_d;
   logic             done_q, done_d;
   logic             greater_q, greater_d, less_q, less_d, equal_q, equal_d;

   logic x, y, rg_n, rl_n, re_n, finish;

   // Chain update for the current MSB pair; only meaningful in SHIFT
   assign x    = sa_q[WIDTH-1];
   assign y    = sb_q[WIDTH-1];
   assign rg_n = rg_q | (re_q & x & ~y);
   assign rl_n = rl_q | (re_q & ~x & y);
   assign re_n = re_q & ~(x ^ y);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   assign finish = (cnt_q == '0) || rg_n || rl_n;
`else
   assign finish = (cnt_q == '0);
`endif

   always_comb begin
      state_d   = state_q;
      sa_d      = sa_q;
      sb_d      = sb_q;
      cnt_d     = cnt_q;
      rg_d      = rg_q;
      rl_d      = rl_q;
      re_d      = re_q;
      done_d    = 1'b0;
      greater_d = greater_q;
      less_d    = less_q;
      equal_d   = equal_q;
      case (state_q)
         IDLE: begin
            if (cmp.start) begin
               sa_d    = cmp.a_in;
               sb_d    = cmp.b_in;
               rg_d    = 1'b0;
               rl_d    = 1'b0;
               re_d    = 1'b1;
               cnt_d   = CW'(WIDTH - 1);
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            rg_d = rg_n;
            rl_d = rl_n;
            re_d = re_n;
            sa_d = sa_q << 1;
            sb_d = sb_q << 1;
            if (finish) begin
               greater_d = rg_n;
               less_d    = rl_n;
               equal_d   = re_n;
               done_d    = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sa_q      <= '0;
         sb_q      <= '0;
         cnt_q     <= '0;
         rg_q      <= 1'b0;
         rl_q      <= 1'b0;
         re_q      <= 1'b0;
         done_q    <= 1'b0;
         greater_q <= 1'b0;
         less_q    <= 1'b0;
         equal_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sa_q      <= sa_d;
         sb_q      <= sb_d;
         cnt_q     <= cnt_d;
         rg_q      <= rg_d;
         rl_q      <= rl_d;
         re_q      <= re_d;
         done_q    <= done_d;
         greater_q <= greater_d;
         less_q    <= less_d;
         equal_q   <= equal_d;
      end
   end

   assign cmp.busy    = (state_q == SHIFT);
   assign cmp.done    = done_q;
   assign cmp.greater = greater_q;
   assign cmp.less    = less_q;
   assign cmp.equal   = equal_q;
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - directed table-driven bench for serial_magnitude_comparator
module tb_serial_magnitude_comparator;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   serial_magnitude_comparator_if #(.WIDTH(8)) cif ();

   serial_magnitude_comparator #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cmp   (cif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] gle;
      int         lat_full;
      int         lat_early;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Latency counts negedges after the accepting edge until done is seen
   task automatic wait_done(output int lat, output int busy_cycles);
      lat = 0;
      busy_cycles = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (cif.done) begin
            lat = i;
            break;
         end
         if (cif.busy) busy_cycles++;
      end
      check("done_timeout", (lat != 0), 1);
   endtask

   task automatic launch(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      cif.a_in  = a;
      cif.b_in  = b;
      cif.start = 1'b1;
      @(posedge clk);
      #1 cif.start = 1'b0;
   endtask

   function automatic int exp_lat(input vec_t v);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      return v.lat_early;
`else
      return v.lat_full;
`endif
   endfunction

   initial begin
      int lat, bc;
      total = 0;
      bad   = 0;
      vecs[0] = '{8'hA5, 8'hA5, 3'b001, 9, 9};
      vecs[1] = '{8'h80, 8'h7F, 3'b100, 9, 2};
      vecs[2] = '{8'h01, 8'h02, 3'b010, 9, 8};
      vecs[3] = '{8'h00, 8'h00, 3'b001, 9, 9};
      vecs[4] = '{8'hFF, 8'hFE, 3'b100, 9, 9};
      vecs[5] = '{8'h7F, 8'h80, 3'b010, 9, 2};
      vecs[6] = '{8'hFF, 8'hFF, 3'b001, 9, 9};
      vecs[7] = '{8'h10, 8'h20, 3'b010, 9, 4};

      cif.start = 1'b0;
      cif.a_in  = '0;
      cif.b_in  = '0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("idle_outputs", {cif.busy, cif.done, cif.greater, cif.less, cif.equal}, 5'b0);
      end

      for (int v = 0; v < 8; v++) begin
         launch(vecs[v].a, vecs[v].b);
         wait_done(lat, bc);
         check("result_gle", {cif.greater, cif.less, cif.equal}, vecs[v].gle);
         check("latency", lat, exp_lat(vecs[v]));
         check("busy_cycles", bc, exp_lat(vecs[v]) - 1);
         check("busy_at_done", cif.busy, 0);
         @(negedge clk);
         check("done_one_cycle", cif.done, 0);
         check("result_hold", {cif.greater, cif.less, cif.equal}, vecs[v].gle);
      end

      // Starts while busy are ignored; a start in the done cycle is accepted
      launch(8'h10, 8'h20);
      @(negedge clk);
      cif.a_in  = 8'hFF;
      cif.b_in  = 8'h00;
      cif.start = 1'b1;
      @(negedge clk);
      check("busy_during_ignored_start", cif.busy, 1);
      cif.start = 1'b0;
      lat = 0;
      for (int i = 3; i <= 40; i++) begin
         @(negedge clk);
         if (cif.done) begin
            lat = i;
            break;
         end
      end
      check("ignore_done_seen", (lat != 0), 1);
      check("ignore_result_less", {cif.greater, cif.less, cif.equal}, 3'b010);
      cif.start = 1'b1;
      @(posedge clk);
      #1 cif.start = 1'b0;
      check("b2b_accepted_busy", cif.busy, 1);
      wait_done(lat, bc);
      check("b2b_result_greater", {cif.greater, cif.less, cif.equal}, 3'b100);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      check("b2b_latency", lat, 2);
`else
      check("b2b_latency", lat, 9);
`endif

      // Asynchronous reset mid-comparison abandons it without a done pulse
      launch(8'h55, 8'h55);
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset_outputs", {cif.busy, cif.done, cif.greater, cif.less, cif.equal}, 5'b0);
      @(negedge clk);
      rst_n = 1'b1;
      bc = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (cif.done || cif.busy) bc++;
      end
      check("no_done_after_reset", bc, 0);
      launch(8'h3C, 8'h3C);
      wait_done(lat, bc);
      check("post_reset_equal", {cif.greater, cif.less, cif.equal}, 3'b001);
      check("post_reset_latency", lat, 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
